// File: rtl/pipeline_ctrl_if.sv
// Hazard/control bundle between the pipeline datapath and the stall/flush
// sequencer. The datapath side uses the master modport; the sequencer
// uses the slave modport.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  // hazard sources reported by the datapath
  logic             ihit;
  logic             dhit;
  logic             mem_dREN;
  logic             mem_dWEN;
  logic             mem_halt;
  logic             br_taken;
  logic             de_jump;
  logic             ex_MemtoReg;
  logic [4:0]       ex_wsel;
  logic [4:0]       de_rs;
  logic [4:0]       de_rt;

  // latch controls returned by the sequencer
  logic             pc_en;
  logic             fl_en;
  logic             fl_flush;
  logic             dl_en;
  logic             dl_flush;
  logic             el_en;
  logic             el_flush;
  logic             ml_en;
  logic             ml_flush;
  logic             ifetch_hold;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, mem_halt, br_taken, de_jump,
           ex_MemtoReg, ex_wsel, de_rs, de_rt,
    input  pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush,
           ml_en, ml_flush, ifetch_hold, halted, stall_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, mem_halt, br_taken, de_jump,
           ex_MemtoReg, ex_wsel, de_rs, de_rt,
    output pc_en, fl_en, fl_flush, dl_en, dl_flush, el_en, el_flush,
           ml_en, ml_flush, ifetch_hold, halted, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Folds I-miss,
// D-miss, load-use, jump, taken-branch and halt into one decision per cycle,
// holds the pipe while a data miss is serviced, and keeps a saturating count
// of cycles in which the pipe did not advance.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input logic            CLK,
  input logic            nRST,
  pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic             mreq;
  logic             adv;
  logic             lu;
  logic             dmiss;
  logic             count_stall;

  assign mreq  = bus.mem_dREN | bus.mem_dWEN;
  assign adv   = bus.ihit & (~mreq | bus.dhit);
  assign dmiss = mreq & ~bus.dhit;
  assign lu    = bus.ex_MemtoReg & (bus.ex_wsel != 5'd0) &
                 ((bus.ex_wsel == bus.de_rs) | (bus.ex_wsel == bus.de_rt));

  assign bus.stall_cnt = cnt_q;

  // Per-cycle latch decision; halt beats a data miss, which beats the
  // advance-time hazards, and a taken branch discards the younger hazards.
  always_comb begin
    bus.pc_en       = 1'b0;
    bus.fl_en       = 1'b0;
    bus.fl_flush    = 1'b0;
    bus.dl_en       = 1'b0;
    bus.dl_flush    = 1'b0;
    bus.el_en       = 1'b0;
    bus.el_flush    = 1'b0;
    bus.ml_en       = 1'b0;
    bus.ml_flush    = 1'b0;
    bus.ifetch_hold = 1'b0;
    bus.halted      = 1'b0;
    count_stall     = 1'b0;
    if (nRST) begin
      case (state)
        RUN: begin
          count_stall = ~adv | lu;
          if (!bus.mem_halt && !dmiss && adv) begin
            bus.pc_en = 1'b1;
            bus.fl_en = 1'b1;
            bus.dl_en = 1'b1;
            bus.el_en = 1'b1;
            bus.ml_en = 1'b1;
            if (bus.br_taken) begin
              bus.fl_flush = 1'b1;
              bus.dl_flush = 1'b1;
              bus.el_flush = 1'b1;
            end else if (lu) begin
              bus.pc_en    = 1'b0;
              bus.fl_en    = 1'b0;
              bus.dl_flush = 1'b1;
            end else if (bus.de_jump) begin
              bus.fl_flush = 1'b1;
            end
          end
        end
        DWAIT: begin
          bus.ifetch_hold = 1'b1;
          count_stall     = 1'b1;
        end
        HALT: begin
          bus.ifetch_hold = 1'b1;
          bus.halted      = 1'b1;
        end
        default: begin
          bus.ifetch_hold = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state plus the saturating perf counter; DWAIT never advances
  // the pipe so each of its cycles is counted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      cnt_q <= '0;
    end else begin
      if (count_stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state)
        RUN: begin
          if (bus.mem_halt) begin
            state <= HALT;
          end else if (dmiss) begin
            state <= DWAIT;
          end
        end
        DWAIT: begin
          if (bus.dhit) begin
            state <= RUN;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for the pipeline stall/flush sequencer. Each scenario task drives
// one cycle at a time, queues the expected outputs and counter value, and
// compares them half a cycle later. A second instance with a 4-bit counter
// covers saturation.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       ihit;
    logic       dhit;
    logic       dren;
    logic       dwen;
    logic       halt;
    logic       br;
    logic       jump;
    logic       mtr;
    logic [4:0] wsel;
    logic [4:0] rs;
    logic [4:0] rt;
  } in_t;

  typedef struct packed {
    logic [10:0] v;
    logic [15:0] cnt;
  } exp_t;

  // bit order: pc_en fl_en fl_flush dl_en dl_flush el_en el_flush ml_en ml_flush ifetch_hold halted
  localparam logic [10:0] EXP_RUN   = 11'b11010101000;
  localparam logic [10:0] EXP_STALL = 11'b00000000000;
  localparam logic [10:0] EXP_DWAIT = 11'b00000000010;
  localparam logic [10:0] EXP_LU    = 11'b00011101000;
  localparam logic [10:0] EXP_BR    = 11'b11111111000;
  localparam logic [10:0] EXP_JMP   = 11'b11110101000;
  localparam logic [10:0] EXP_HALT  = 11'b00000000011;

  logic        CLK;
  logic        nRST;
  int          checks;
  int          errors;
  exp_t        sb[$];
  logic [10:0] obs;
  logic [10:0] obs4;

  pipeline_ctrl_if #(.CNT_W(16)) bus ();
  pipeline_ctrl_if #(.CNT_W(4))  bus4 ();

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus4.slave)
  );

  assign obs  = {bus.pc_en, bus.fl_en, bus.fl_flush, bus.dl_en, bus.dl_flush,
                 bus.el_en, bus.el_flush, bus.ml_en, bus.ml_flush,
                 bus.ifetch_hold, bus.halted};
  assign obs4 = {bus4.pc_en, bus4.fl_en, bus4.fl_flush, bus4.dl_en, bus4.dl_flush,
                 bus4.el_en, bus4.el_flush, bus4.ml_en, bus4.ml_flush,
                 bus4.ifetch_hold, bus4.halted};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic in_t mk(input logic ihit, input logic dhit, input logic dren,
                             input logic dwen, input logic halt, input logic br,
                             input logic jump, input logic mtr, input logic [4:0] wsel,
                             input logic [4:0] rs, input logic [4:0] rt);
    in_t i;
    i.ihit = ihit; i.dhit = dhit; i.dren = dren; i.dwen = dwen;
    i.halt = halt; i.br = br; i.jump = jump; i.mtr = mtr;
    i.wsel = wsel; i.rs = rs; i.rt = rt;
    return i;
  endfunction

  function automatic in_t idle();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2);
  endfunction

  task automatic apply_in(input in_t i);
    bus.ihit = i.ihit; bus.dhit = i.dhit; bus.mem_dREN = i.dren; bus.mem_dWEN = i.dwen;
    bus.mem_halt = i.halt; bus.br_taken = i.br; bus.de_jump = i.jump;
    bus.ex_MemtoReg = i.mtr; bus.ex_wsel = i.wsel; bus.de_rs = i.rs; bus.de_rt = i.rt;
  endtask

  task automatic apply_in4(input in_t i);
    bus4.ihit = i.ihit; bus4.dhit = i.dhit; bus4.mem_dREN = i.dren; bus4.mem_dWEN = i.dwen;
    bus4.mem_halt = i.halt; bus4.br_taken = i.br; bus4.de_jump = i.jump;
    bus4.ex_MemtoReg = i.mtr; bus4.ex_wsel = i.wsel; bus4.de_rs = i.rs; bus4.de_rt = i.rt;
  endtask

  // drive one cycle's inputs just after the edge and queue what must appear
  task automatic drive(input in_t i, input logic [10:0] ev, input logic [15:0] ec);
    @(posedge CLK);
    #1;
    apply_in(i);
    sb.push_back('{v: ev, cnt: ec});
  endtask

  // asynchronous reset: outputs must drop without waiting for a clock edge
  task automatic test_reset();
    exp_t e;
    @(posedge CLK);
    #1;
    apply_in(idle());
    apply_in4(idle());
    nRST = 1'b0;
    sb.push_back('{v: EXP_STALL, cnt: 16'd0});
    #2;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL reset: got out=%b cnt=%0d, want out=%b cnt=%0d", obs, bus.stall_cnt, e.v, e.cnt);
    end
    checks++;
    if (obs4 !== EXP_STALL || bus4.stall_cnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset4: got out=%b cnt=%0d, want out=%b cnt=0", obs4, bus4.stall_cnt, EXP_STALL);
    end
    #2;
    nRST = 1'b1;
  endtask

  task automatic test_run();
    in_t         stim [7];
    logic [10:0] ev [7];
    logic [15:0] ec [7];
    exp_t        e;
    stim = '{idle(), idle(),
             mk(1, 1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2),
             mk(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0),
             mk(1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd4),
             mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2),
             idle()};
    ev = '{EXP_RUN, EXP_RUN, EXP_RUN, EXP_RUN, EXP_RUN, EXP_STALL, EXP_RUN};
    ec = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    for (int k = 0; k < 7; k++) begin
      drive(stim[k], ev[k], ec[k]);
      #4;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL run[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", k, obs, bus.stall_cnt, e.v, e.cnt);
      end
    end
  endtask

  task automatic test_dmiss();
    in_t         stim [5];
    logic [10:0] ev [5];
    logic [15:0] ec [5];
    exp_t        e;
    stim = '{mk(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2),
             mk(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2),
             mk(1, 0, 1, 0, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2),
             mk(1, 1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2),
             idle()};
    ev = '{EXP_STALL, EXP_DWAIT, EXP_DWAIT, EXP_DWAIT, EXP_RUN};
    ec = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    for (int k = 0; k < 5; k++) begin
      drive(stim[k], ev[k], ec[k]);
      #4;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL dmiss[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", k, obs, bus.stall_cnt, e.v, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    in_t         stim [5];
    logic [10:0] ev [5];
    logic [15:0] ec [5];
    exp_t        e;
    stim = '{mk(1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5),
             mk(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2),
             mk(1, 0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd1, 5'd2),
             mk(1, 0, 0, 0, 0, 0, 1, 1, 5'd9, 5'd1, 5'd9),
             idle()};
    ev = '{EXP_LU, EXP_LU, EXP_JMP, EXP_LU, EXP_RUN};
    ec = '{16'd5, 16'd6, 16'd7, 16'd7, 16'd8};
    for (int k = 0; k < 5; k++) begin
      drive(stim[k], ev[k], ec[k]);
      #4;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL load_use[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", k, obs, bus.stall_cnt, e.v, e.cnt);
      end
    end
  endtask

  task automatic test_branch();
    in_t         stim [4];
    logic [10:0] ev [4];
    logic [15:0] ec [4];
    exp_t        e;
    stim = '{mk(1, 0, 0, 0, 0, 1, 1, 1, 5'd3, 5'd3, 5'd2),
             mk(1, 0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2),
             mk(0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd1, 5'd2),
             idle()};
    ev = '{EXP_BR, EXP_BR, EXP_STALL, EXP_RUN};
    ec = '{16'd8, 16'd9, 16'd9, 16'd10};
    for (int k = 0; k < 4; k++) begin
      drive(stim[k], ev[k], ec[k]);
      #4;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL branch[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", k, obs, bus.stall_cnt, e.v, e.cnt);
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    in_t  r;
    drive(mk(1, 0, 0, 0, 1, 1, 0, 0, 5'd0, 5'd1, 5'd2), EXP_STALL, 16'd10);
    #4;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL halt_entry: got out=%b cnt=%0d, want out=%b cnt=%0d", obs, bus.stall_cnt, e.v, e.cnt);
    end
    for (int k = 0; k < 10; k++) begin
      r = in_t'($urandom);
      drive(r, EXP_HALT, 16'd10);
      #4;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL halt_hold[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", k, obs, bus.stall_cnt, e.v, e.cnt);
      end
    end
    test_reset();
    drive(idle(), EXP_RUN, 16'd0);
    #4;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL halt_cleared: got out=%b cnt=%0d, want out=%b cnt=%0d", obs, bus.stall_cnt, e.v, e.cnt);
    end
  endtask

  task automatic test_dwait_reset();
    exp_t e;
    drive(mk(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2), EXP_STALL, 16'd0);
    #4;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL dwr_miss: got out=%b cnt=%0d, want out=%b cnt=%0d", obs, bus.stall_cnt, e.v, e.cnt);
    end
    drive(mk(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2), EXP_DWAIT, 16'd1);
    #4;
    e = sb.pop_front();
    checks++;
    if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL dwr_wait: got out=%b cnt=%0d, want out=%b cnt=%0d", obs, bus.stall_cnt, e.v, e.cnt);
    end
    test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(idle(), EXP_RUN, 16'd0);
      #4;
      e = sb.pop_front();
      checks++;
      if (obs !== e.v || bus.stall_cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL dwr_after[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", k, obs, bus.stall_cnt, e.v, e.cnt);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int k = 0; k < 21; k++) begin
      @(posedge CLK);
      #1;
      apply_in4(mk(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2));
      sb.push_back('{v: EXP_STALL, cnt: (k > 15) ? 16'd15 : 16'(k)});
      #4;
      e = sb.pop_front();
      checks++;
      if (obs4 !== e.v || {12'd0, bus4.stall_cnt} !== e.cnt) begin
        errors++;
        $display("[TB] FAIL saturate[%0d]: got out=%b cnt=%0d, want out=%b cnt=%0d", k, obs4, bus4.stall_cnt, e.v, e.cnt);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST   = 1'b0;
    apply_in(idle());
    apply_in4(idle());
    test_reset();
    test_run();
    test_dmiss();
    test_load_use();
    test_branch();
    test_halt();
    test_dwait_reset();
    test_reset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
